// File: rtl/outer_seq_pkg.sv
// -----------------------------------------------------------------------------
// outer_seq_pkg
// Shared definitions for the blitter outer-loop sequencer. This package holds
// the outer count width and the sequencer state encoding, so the top and the
// down counter agree on both.
// Configuration macro used by importers: OUTER_ADDR_UPD_EN
// (when it is defined, the UPDATE state is used between lines).
// -----------------------------------------------------------------------------
package outer_seq_pkg;

  // Width of the outer (line) count.
  localparam int CNT_W = 16;

  // Sequencer states. ST_UPDATE is only reached when OUTER_ADDR_UPD_EN is set.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STEP   = 3'd4,
    ST_UPDATE = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/outer_dcnt.sv
// -----------------------------------------------------------------------------
// outer_dcnt
// A loadable CNT_W-bit down counter with a zero flag. It holds the outer line
// count of the sequencer.
// Ports:
//   clk_i      in   clock; the count changes on the rising edge
//   resetl_i   in   asynchronous active-low reset; clears the count to 0
//   load_i     in   load load_val_i. Load has priority over ena_i.
//   ena_i      in   decrement by one. This is ignored while the count is 0.
//   load_val_i in   value to load
//   count_o    out  current count
//   zero_o     out  combinational flag: count_o == 0
// -----------------------------------------------------------------------------
module outer_dcnt
  import outer_seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             resetl_i,
  input  logic             load_i,
  input  logic             ena_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count. The zero guard means the counter can never wrap to all ones,
  // even if a caller asserts ena_i while the count is already 0.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (ena_i && !zero_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge resetl_i) begin
    if (!resetl_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The zero flag is a NOR reduction of the count. It has no register.
  assign zero_o  = ~|cnt_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/outer_seq.sv
// -----------------------------------------------------------------------------
// outer_seq
// Blitter outer-loop sequencer. It runs one "line" at a time:
//   - it launches the inner loop,
//   - it waits for the inner loop to finish,
//   - it steps the line count down by one,
//   - when OUTER_ADDR_UPD_EN is defined, it strobes the address registers for
//     UPD_CYCLES cycles before the next line starts.
// When the last line finishes, it pulses done.
//
// Configuration macro: OUTER_ADDR_UPD_EN
//   defined   -> the UPDATE state and its 4-bit cycle counter are built.
//   undefined -> STEP goes straight to RUN, a_upd is tied to 0, and
//                UPD_CYCLES is only range-checked.
//
// Parameters:
//   UPD_CYCLES  number of cycles spent in UPDATE for each line (1..15)
// Ports:
//   clk         in   clock
//   resetl      in   asynchronous active-low reset
//   start       in   one-cycle request to begin a block. It is ignored while busy.
//   stop        in   abort. It returns to IDLE and gives no done pulse.
//   count_in    in   number of lines. It is sampled on the start cycle.
//   inner_done  in   pulse from the inner loop: the current line is finished
//   inner_go    out  one-cycle pulse that launches the inner loop for one line
//   a_upd       out  high during every UPDATE cycle
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse on normal completion
//   outer0      out  high when ocount == 0 (combinational)
//   ocount      out  current outer count
// -----------------------------------------------------------------------------
module outer_seq
  import outer_seq_pkg::*;
#(
  parameter int UPD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] count_in,
  input  logic             inner_done,
  output logic             inner_go,
  output logic             a_upd,
  output logic             busy,
  output logic             done,
  output logic             outer0,
  output logic [CNT_W-1:0] ocount
);

  // Reject an out-of-range update length at elaboration time.
  if (UPD_CYCLES < 1 || UPD_CYCLES > 15) begin : g_bad_upd_cycles
    $error("outer_seq: UPD_CYCLES must be in 1..15");
  end

  state_e state_q;
  state_e state_d;

  logic inner_go_q;
  logic busy_q;
  logic done_q;

  logic cnt_load;
  logic cnt_ena;
  logic last_line;

  // The line counter is loaded on an accepted start. It is decremented only
  // when the sequencer leaves STEP. STEP cannot be reached with a count of 0,
  // so the count never wraps.
  assign cnt_load  = (state_q == ST_IDLE) && start && !stop;
  assign cnt_ena   = (state_q == ST_STEP) && !stop;
  assign last_line = (ocount == CNT_W'(1));

  outer_dcnt u_dcnt (
    .clk_i      (clk),
    .resetl_i   (resetl),
    .load_i     (cnt_load),
    .ena_i      (cnt_ena),
    .load_val_i (count_in),
    .count_o    (ocount),
    .zero_o     (outer0)
  );

`ifdef OUTER_ADDR_UPD_EN
  localparam logic [3:0] UPD_LAST = 4'(UPD_CYCLES - 1);

  logic [3:0] upd_cnt_q;
  logic [3:0] upd_cnt_d;
  logic       a_upd_q;

  // Count the cycles spent in UPDATE. The counter is held at 0 in every other
  // state, so each new burst starts from zero.
  always_comb begin
    upd_cnt_d = 4'd0;
    if (state_q == ST_UPDATE && state_d == ST_UPDATE) begin
      upd_cnt_d = upd_cnt_q + 4'd1;
    end
  end

  // UPDATE cycle counter register.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      upd_cnt_q <= 4'd0;
    end else begin
      upd_cnt_q <= upd_cnt_d;
    end
  end

  assign a_upd = a_upd_q;
`else
  assign a_upd = 1'b0;
`endif

  // Next-state logic. Stop overrides every other transition. A start pulse is
  // only acted on in IDLE.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (start) state_d = ST_LOAD;
        ST_LOAD:   state_d = outer0 ? ST_DONE : ST_RUN;
        ST_RUN:    state_d = ST_WAIT;
        ST_WAIT:   if (inner_done) state_d = ST_STEP;
`ifdef OUTER_ADDR_UPD_EN
        ST_STEP:   state_d = last_line ? ST_DONE : ST_UPDATE;
        ST_UPDATE: if (upd_cnt_q == UPD_LAST) state_d = ST_RUN;
`else
        ST_STEP:   state_d = last_line ? ST_DONE : ST_RUN;
`endif
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // State register. The outputs are registered here and decoded from the next
  // state, so each strobe is high for exactly the cycles spent in its state.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q    <= ST_IDLE;
      inner_go_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef OUTER_ADDR_UPD_EN
      a_upd_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      inner_go_q <= (state_d == ST_RUN);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
`ifdef OUTER_ADDR_UPD_EN
      a_upd_q    <= (state_d == ST_UPDATE);
`endif
    end
  end

  assign inner_go = inner_go_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_outer_seq.sv
// -----------------------------------------------------------------------------
// tb_outer_seq
// Testbench for outer_seq.
// The expected behaviour is built as a per-cycle timeline from the line rules:
//   - the first inner_go comes 2 cycles after start,
//   - the next inner_go comes 2 (+U) cycles after inner_done,
//   - done comes 2 cycles after the last inner_done,
//   - the count drops one cycle after each STEP.
// The stimulus is then replayed against the design, one cycle at a time.
// Building with OUTER_ADDR_UPD_EN defined enables the UPDATE expectations.
// -----------------------------------------------------------------------------
module tb_outer_seq;

  localparam int MAXC = 256;
`ifdef OUTER_ADDR_UPD_EN
  localparam int U = 3;
`else
  localparam int U = 0;
`endif

  logic        clk;
  logic        resetl;
  logic        start;
  logic        stop;
  logic [15:0] count_in;
  logic        inner_done;
  logic        inner_go;
  logic        a_upd;
  logic        busy;
  logic        done;
  logic        outer0;
  logic [15:0] ocount;

  int total;
  int bad;
  int prevOcnt;

  bit eg[MAXC];
  bit eu[MAXC];
  bit eb[MAXC];
  bit ed[MAXC];
  bit idn[MAXC];
  int eo[MAXC];

  outer_seq #(.UPD_CYCLES(3)) dut (
    .clk        (clk),
    .resetl     (resetl),
    .start      (start),
    .stop       (stop),
    .count_in   (count_in),
    .inner_done (inner_done),
    .inner_go   (inner_go),
    .a_upd      (a_upd),
    .busy       (busy),
    .done       (done),
    .outer0     (outer0),
    .ocount     (ocount)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build the expected timeline for one block operation, then drive it and
  // check every cycle. Cycle 0 is the start cycle. It must be entered just
  // after a rising edge.
  task automatic run_op(input int n, input int stopCyc, input int xStartCyc,
                        input int dly, output int goSeen, output int updSeen,
                        output int doneSeen, output int busySeen);
    int g, d, st, lastC, oc, horizon, held;
    logic [20:0] obs, exp;
    for (int c = 0; c < MAXC; c++) begin
      eg[c] = 0; eu[c] = 0; eb[c] = 0; ed[c] = 0; idn[c] = 0; eo[c] = prevOcnt;
    end
    if (n == 0) begin
      for (int c = 1; c < MAXC; c++) eo[c] = 0;
      eb[1] = 1; eb[2] = 1; ed[2] = 1; lastC = 2;
    end else begin
      for (int c = 1; c < MAXC; c++) eo[c] = n;
      oc = n; g = 2; lastC = MAXC - 1;
      while (oc > 0 && g < MAXC - 20) begin
        d = g + ((dly > 0) ? dly : int'($urandom_range(1, 6)));
        eg[g] = 1; idn[d] = 1;
        st = d + 1;
        oc--;
        for (int c = st + 1; c < MAXC; c++) eo[c] = oc;
        if (oc == 0) begin
          ed[st + 1] = 1; lastC = st + 1;
        end else begin
          for (int c = st + 1; c <= st + U; c++) eu[c] = 1;
          g = st + 1 + U;
        end
      end
      for (int c = 1; c <= lastC; c++) eb[c] = 1;
    end
    horizon = lastC + 2;
    if (stopCyc >= 0) begin
      held = (stopCyc == 0) ? prevOcnt : eo[stopCyc];
      for (int c = stopCyc + 1; c < MAXC; c++) begin
        eg[c] = 0; eu[c] = 0; eb[c] = 0; ed[c] = 0; eo[c] = held;
      end
      if (stopCyc == 0) begin
        for (int c = 0; c < MAXC; c++) eo[c] = prevOcnt;
      end
      horizon = stopCyc + 3;
    end
    if (horizon > MAXC - 1) horizon = MAXC - 1;

    goSeen = 0; updSeen = 0; doneSeen = 0; busySeen = 0;
    for (int c = 0; c <= horizon; c++) begin
      start      = (c == 0) || (c == xStartCyc);
      count_in   = (c == 0) ? 16'(n) : ((c == xStartCyc) ? 16'd9 : 16'($urandom));
      stop       = (c == stopCyc);
      inner_done = idn[c];
      @(negedge clk);
      obs = {inner_go, a_upd, busy, done, outer0, ocount};
      exp = {eg[c], eu[c], eb[c], ed[c], (eo[c] == 0), 16'(eo[c])};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL cycle%0d go/upd/busy/done/outer0/ocount got %b %b %b %b %b %h want %b %b %b %b %b %h",
                 c, obs[20], obs[19], obs[18], obs[17], obs[16], obs[15:0],
                 exp[20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
      end
      goSeen   += int'(inner_go);
      updSeen  += int'(a_upd);
      doneSeen += int'(done);
      busySeen += int'(busy);
      @(posedge clk);
      #1;
    end
    start = 0; stop = 0; inner_done = 0;
    prevOcnt = eo[horizon];
  endtask

  // Check the values held during reset and just after it is released.
  task automatic test_reset();
    resetl = 1'b0; start = 0; stop = 0; inner_done = 0; count_in = 16'h1234;
    #12;
    total++;
    if ({inner_go, a_upd, busy, done, outer0, ocount} !== {5'b00001, 16'h0000}) begin
      bad++;
      $display("[TB] FAIL reset_state got %b%b%b%b%b %h want 00001 0000",
               inner_go, a_upd, busy, done, outer0, ocount);
    end
    #3 resetl = 1'b1;
    @(posedge clk); #1;
    prevOcnt = 0;
  endtask

  // Three lines, inner loop answering 5 cycles after each launch.
  task automatic test_basic();
    int go, up, dn, bz;
    run_op(3, -1, -1, 5, go, up, dn, bz);
    total++;
    if (go !== 3 || dn !== 1 || outer0 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL basic_counts go=%0d done=%0d outer0=%b want 3 1 1", go, dn, outer0);
    end
  endtask

  // A zero-line operation: no launch, done after 2 cycles, busy for 2 cycles.
  task automatic test_zero();
    int go, up, dn, bz;
    run_op(0, -1, -1, 1, go, up, dn, bz);
    total++;
    if (go !== 0 || dn !== 1 || bz !== 2) begin
      bad++;
      $display("[TB] FAIL zero_line go=%0d done=%0d busy=%0d want 0 1 2", go, dn, bz);
    end
  endtask

  // Two lines: one address-update burst between them, none after the last.
  task automatic test_update();
    int go, up, dn, bz;
    run_op(2, -1, -1, int'($urandom_range(1, 6)), go, up, dn, bz);
    total++;
    if (go !== 2 || up !== U) begin
      bad++;
      $display("[TB] FAIL update_burst go=%0d upd=%0d want 2 %0d", go, up, U);
    end
  endtask

  // Abort during the WAIT of line 2, a clean single-line run afterwards, and
  // a start and stop in the same cycle while IDLE.
  task automatic test_stop();
    int go, up, dn, bz;
    run_op(4, 9 + U, -1, 3, go, up, dn, bz);
    total++;
    if (ocount !== 16'd3 || dn !== 0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stop_wait ocount=%h done=%0d busy=%b want 0003 0 0", ocount, dn, busy);
    end
    run_op(1, -1, -1, 4, go, up, dn, bz);
    total++;
    if (go !== 1 || dn !== 1 || ocount !== 16'd0) begin
      bad++;
      $display("[TB] FAIL after_stop go=%0d done=%0d ocount=%h want 1 1 0000", go, dn, ocount);
    end
    run_op(6, 0, -1, 2, go, up, dn, bz);
    total++;
    if (bz !== 0 || ocount !== 16'd0) begin
      bad++;
      $display("[TB] FAIL start_stop_same busy=%0d ocount=%h want 0 0000", bz, ocount);
    end
  endtask

  // A start pulse while busy (count_in=9) must be ignored. Then reset is
  // asserted in the middle of RUN.
  task automatic test_back_to_back();
    int go, up, dn, bz;
    run_op(5, -1, 4, 5, go, up, dn, bz);
    total++;
    if (go !== 5 || dn !== 1) begin
      bad++;
      $display("[TB] FAIL start_busy go=%0d done=%0d want 5 1", go, dn);
    end
    start = 1; count_in = 16'd7;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    total++;
    if (inner_go !== 1'b1 || ocount !== 16'd7) begin
      bad++;
      $display("[TB] FAIL run_entry inner_go=%b ocount=%h want 1 0007", inner_go, ocount);
    end
    #1 resetl = 1'b0;
    #1;
    total++;
    if ({inner_go, a_upd, busy, done, outer0, ocount} !== {5'b00001, 16'h0000}) begin
      bad++;
      $display("[TB] FAIL async_reset got %b%b%b%b%b %h want 00001 0000",
               inner_go, a_upd, busy, done, outer0, ocount);
    end
    @(negedge clk); #2 resetl = 1'b1;
    @(posedge clk); #1;
    prevOcnt = 0;
  endtask

  // Maximum count: the first decrement gives FFFE and outer0 stays low.
  task automatic test_ffff();
    int go, up, dn, bz;
    run_op(65535, 7, -1, 2, go, up, dn, bz);
    total++;
    if (ocount !== 16'hFFFE || outer0 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL max_count ocount=%h outer0=%b want fffe 0", ocount, outer0);
    end
  endtask

  // Random line counts and inner-loop delays, with an occasional abort.
  task automatic test_random();
    int go, up, dn, bz, n, sc;
    for (int i = 0; i < 8; i++) begin
      n  = int'($urandom_range(1, 5));
      sc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
      run_op(n, sc, -1, 0, go, up, dn, bz);
    end
  endtask

  // Run the scenarios in order, then print the summary line.
  initial begin
    total = 0; bad = 0; prevOcnt = 0;
    test_reset();
    test_basic();
    test_zero();
    test_update();
    test_stop();
    test_back_to_back();
    test_ffff();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
